// File: rtl/hmm_pkg.sv
// Shared sizing, types and FSM encoding for the HMM Viterbi traceback engine.
// Optional HMM_TB_STEP_IDX_EN adds a time-index output (see hmm_traceback).
package hmm_pkg;

   localparam int unsigned NSTATES = 4;
   localparam int unsigned PTR_W   = 2;
   localparam int unsigned T_MAX   = 32;
   localparam int unsigned IDX_W   = 5;

   typedef logic [PTR_W-1:0]         state_t;
   typedef logic [NSTATES*PTR_W-1:0] sv_t;
   typedef logic [IDX_W-1:0]         idx_t;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      TRACE = 2'd1,
      DONE  = 2'd2
   } tb_state_e;

   localparam idx_t LAST_IDX = idx_t'(T_MAX - 1);

endpackage

// File: rtl/hmm_traceback_if.sv
// Survivor-vector input stream and decoded-path output stream of the traceback engine.
// With HMM_TB_STEP_IDX_EN defined the output side also carries out_idx.
interface hmm_traceback_if
   import hmm_pkg::*;
;
   logic   sv_valid;
   logic   sv_ready;
   sv_t    sv_ptrs;
   logic   sv_last;
   state_t final_state;
   logic   out_valid;
   logic   out_ready;
   state_t out_state;
   logic   out_last;
   logic   done;
   logic   err_ovf;
`ifdef HMM_TB_STEP_IDX_EN
   idx_t   out_idx;

   modport master (
      output sv_valid, sv_ptrs, sv_last, final_state, out_ready,
      input  sv_ready, out_valid, out_state, out_last, done, err_ovf, out_idx
   );
   modport slave (
      input  sv_valid, sv_ptrs, sv_last, final_state, out_ready,
      output sv_ready, out_valid, out_state, out_last, done, err_ovf, out_idx
   );
`else
   modport master (
      output sv_valid, sv_ptrs, sv_last, final_state, out_ready,
      input  sv_ready, out_valid, out_state, out_last, done, err_ovf
   );
   modport slave (
      input  sv_valid, sv_ptrs, sv_last, final_state, out_ready,
      output sv_ready, out_valid, out_state, out_last, done, err_ovf
   );
`endif
endinterface

// File: rtl/hmm_tb_ptr_mem.sv
// Survivor pointer store: T_MAX rows of NSTATES backpointers, one write port and a
// combinational read port that returns the backpointer of one selected state.
module hmm_tb_ptr_mem
   import hmm_pkg::*;
(
   input  logic   clk,
   input  logic   we,
   input  idx_t   waddr,
   input  sv_t    wdata,
   input  idx_t   raddr,
   input  state_t rsel,
   output state_t rdata
);

   sv_t mem [T_MAX];
   sv_t row;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign row = mem[raddr];

   always_comb begin
      rdata = '0;
      for (int s = 0; s < NSTATES; s++) begin
         if (rsel == state_t'(s)) begin
            rdata = row[s*PTR_W +: PTR_W];
         end
      end
   end

endmodule

// File: rtl/hmm_traceback.sv
// Viterbi traceback: buffers survivor vectors, then walks backpointers from the end state
// and streams the path in reverse time order. HMM_TB_STEP_IDX_EN adds out_idx.
module hmm_traceback
   import hmm_pkg::*;
(
   input logic            clk,
   input logic            rst_n,
   hmm_traceback_if.slave bus
);

   tb_state_e st_q, st_d;
   idx_t      wr_idx_q, wr_idx_d;
   idx_t      t_q, t_d;
   state_t    cur_q, cur_d;
   logic      err_q, err_d;
   state_t    prev_state;
   logic      sv_hs;
   logic      out_hs;

   assign sv_hs  = bus.sv_valid & bus.sv_ready;
   assign out_hs = bus.out_valid & bus.out_ready;

   hmm_tb_ptr_mem u_mem (
      .clk   (clk),
      .we    (sv_hs),
      .waddr (wr_idx_q),
      .wdata (bus.sv_ptrs),
      .raddr (t_q),
      .rsel  (cur_q),
      .rdata (prev_state)
   );

   always_comb begin
      st_d     = st_q;
      wr_idx_d = wr_idx_q;
      t_d      = t_q;
      cur_d    = cur_q;
      err_d    = err_q;
      unique case (st_q)
         FILL: begin
            if (sv_hs) begin
               if (bus.sv_last || (wr_idx_q == LAST_IDX)) begin
                  t_d   = wr_idx_q;
                  cur_d = bus.final_state;
                  st_d  = TRACE;
                  // Buffer full without an end marker: trace anyway, flag it.
                  if (!bus.sv_last) begin
                     err_d = 1'b1;
                  end
               end else begin
                  wr_idx_d = wr_idx_q + idx_t'(1);
               end
            end
         end
         TRACE: begin
            if (out_hs) begin
               if (t_q == '0) begin
                  st_d = DONE;
               end else begin
                  cur_d = prev_state;
                  t_d   = t_q - idx_t'(1);
               end
            end
         end
         DONE: begin
            wr_idx_d = '0;
            st_d     = FILL;
         end
         default: st_d = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q     <= FILL;
         wr_idx_q <= '0;
         t_q      <= '0;
         cur_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         st_q     <= st_d;
         wr_idx_q <= wr_idx_d;
         t_q      <= t_d;
         cur_q    <= cur_d;
         err_q    <= err_d;
      end
   end

   assign bus.sv_ready  = (st_q == FILL);
   assign bus.out_valid = (st_q == TRACE);
   assign bus.out_state = cur_q;
   assign bus.out_last  = (st_q == TRACE) && (t_q == '0);
   assign bus.done      = (st_q == DONE);
   assign bus.err_ovf   = err_q;
`ifdef HMM_TB_STEP_IDX_EN
   assign bus.out_idx   = t_q;
`endif

endmodule

// File: tb/tb_hmm_traceback.sv
// Directed self-checking bench for hmm_traceback; checks out_idx when HMM_TB_STEP_IDX_EN is set.
module tb_hmm_traceback;
   import hmm_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hmm_traceback_if bus ();

   hmm_traceback dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   state_t exp_st [T_MAX];
   logic ready_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_vec(input sv_t p, input logic last, input state_t fs);
      bus.sv_valid    = 1'b1;
      bus.sv_ptrs     = p;
      bus.sv_last     = last;
      bus.final_state = fs;
      n_cmp++;
      if (bus.sv_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL sv_ready_fill: got %b want 1", bus.sv_ready);
      end
      tick();
      bus.sv_valid = 1'b0;
      bus.sv_last  = 1'b0;
   endtask

   task automatic send_seq4();
      send_vec(8'h00, 1'b0, 2'd0);
      send_vec(8'hE4, 1'b0, 2'd0);
      send_vec(8'h1B, 1'b0, 2'd0);
      send_vec(8'h55, 1'b1, 2'd2);
   endtask

   // Drains n path elements, checking order, out_last, stall stability and the done pulse.
   task automatic collect(input int n, input bit bp, input string tag);
      int     k = 0;
      int     cyc = 0;
      bit     stalled = 1'b0;
      state_t held_st = '0;
      logic   held_last = 1'b0;
      while (k < n && cyc < 400) begin
         bus.out_ready = bp ? ready_pat[cyc % 4] : 1'b1;
         n_cmp++;
         if (bus.out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL %s out_valid[%0d]: got %b want 1", tag, k, bus.out_valid);
            break;
         end
         if (stalled) begin
            n_cmp++;
            if (bus.out_state !== held_st || bus.out_last !== held_last) begin
               n_bad++;
               $display("FAIL %s stall_hold[%0d]: got %0d/%b want %0d/%b", tag, k,
                        bus.out_state, bus.out_last, held_st, held_last);
            end
         end
         n_cmp++;
         if (bus.out_state !== exp_st[k]) begin
            n_bad++;
            $display("FAIL %s out_state[%0d]: got %0d want %0d", tag, k, bus.out_state, exp_st[k]);
         end
         n_cmp++;
         if (bus.out_last !== (k == n - 1)) begin
            n_bad++;
            $display("FAIL %s out_last[%0d]: got %b want %b", tag, k, bus.out_last, (k == n - 1));
         end
`ifdef HMM_TB_STEP_IDX_EN
         n_cmp++;
         if (bus.out_idx !== idx_t'(n - 1 - k)) begin
            n_bad++;
            $display("FAIL %s out_idx[%0d]: got %0d want %0d", tag, k, bus.out_idx, n - 1 - k);
         end
`endif
         stalled   = !bus.out_ready;
         held_st   = bus.out_state;
         held_last = bus.out_last;
         if (bus.out_ready) k++;
         tick();
         cyc++;
      end
      bus.out_ready = 1'b0;
      n_cmp++;
      if (k != n) begin
         n_bad++;
         $display("FAIL %s element_count: got %0d want %0d", tag, k, n);
      end
      n_cmp++;
      if (bus.done !== 1'b1 || bus.out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL %s done_pulse: got done=%b valid=%b want 1/0", tag, bus.done, bus.out_valid);
      end
      tick();
      n_cmp++;
      if (bus.done !== 1'b0 || bus.sv_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL %s after_done: got done=%b sv_ready=%b want 0/1", tag, bus.done,
                  bus.sv_ready);
      end
   endtask

   task automatic check_idle(input string tag, input logic exp_err);
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.sv_ready !== 1'b1 || bus.out_last !== 1'b0 ||
          bus.done !== 1'b0 || bus.err_ovf !== exp_err) begin
         n_bad++;
         $display("FAIL %s idle: got valid=%b ready=%b last=%b done=%b ovf=%b want 0/1/0/0/%b",
                  tag, bus.out_valid, bus.sv_ready, bus.out_last, bus.done, bus.err_ovf, exp_err);
      end
   endtask

   task automatic test_reset();
      #2;
      check_idle("reset", 1'b0);
      n_cmp++;
      if (bus.out_state !== 2'd0) begin
         n_bad++;
         $display("FAIL reset out_state: got %0d want 0", bus.out_state);
      end
`ifdef HMM_TB_STEP_IDX_EN
      n_cmp++;
      if (bus.out_idx !== '0) begin
         n_bad++;
         $display("FAIL reset out_idx: got %0d want 0", bus.out_idx);
      end
`endif
      rst_n = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_four_step();
      send_seq4();
      exp_st[0] = 2'd2; exp_st[1] = 2'd1; exp_st[2] = 2'd2; exp_st[3] = 2'd2;
      collect(4, 1'b0, "four_step");
      check_idle("four_step_end", 1'b0);
   endtask

   task automatic test_backpressure();
      send_seq4();
      exp_st[0] = 2'd2; exp_st[1] = 2'd1; exp_st[2] = 2'd2; exp_st[3] = 2'd2;
      collect(4, 1'b1, "backpressure");
   endtask

   task automatic test_single();
      send_vec(8'hAA, 1'b1, 2'd3);
      exp_st[0] = 2'd3;
      collect(1, 1'b0, "single");
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 32; i++) begin
         send_vec(8'hE4, 1'b0, (i == 31) ? 2'd1 : 2'd0);
      end
      n_cmp++;
      if (bus.err_ovf !== 1'b1) begin
         n_bad++;
         $display("FAIL overflow err_ovf_set: got %b want 1", bus.err_ovf);
      end
      for (int i = 0; i < 32; i++) exp_st[i] = 2'd1;
      collect(32, 1'b0, "overflow");
      check_idle("overflow_sticky", 1'b1);
   endtask

   task automatic test_reset_mid();
      send_seq4();
      bus.out_ready = 1'b1;
      tick();
      tick();
      bus.out_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      check_idle("reset_mid", 1'b0);
      #2;
      rst_n = 1'b1;
      tick();
      send_vec(8'h00, 1'b0, 2'd0);
      send_vec(8'h1B, 1'b1, 2'd0);
      exp_st[0] = 2'd0; exp_st[1] = 2'd3;
      collect(2, 1'b0, "after_reset");
   endtask

   initial begin
      bus.sv_valid    = 1'b0;
      bus.sv_ptrs     = '0;
      bus.sv_last     = 1'b0;
      bus.final_state = '0;
      bus.out_ready   = 1'b0;
      test_reset();
      test_four_step();
      test_backpressure();
      test_single();
      test_overflow();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
